// File: rtl/test_seq_pkg.sv
// Shared types and defaults for the test sequencer: FSM state encoding and
// default sizing parameters.
package test_seq_pkg;

  localparam int N_TESTS_DEF   = 4;
  localparam int TIMEOUT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  function automatic logic is_busy(seq_state_e s);
    return (s == ST_SELECT) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// Bundles for the sequencer: the start/done/fail bus towards the test units
// and the control/status link to the per-test timeout timer.
interface test_sequencer_if #(
  parameter int N_TESTS = test_seq_pkg::N_TESTS_DEF
);
  logic [N_TESTS-1:0] test_start;
  logic [N_TESTS-1:0] test_done;
  logic [N_TESTS-1:0] test_fail;

  modport master (output test_start, input test_done, input test_fail);
  modport slave  (input test_start, output test_done, output test_fail);
endinterface

interface tseq_timer_if #(
  parameter int TIMEOUT_W = test_seq_pkg::TIMEOUT_W_DEF
);
  logic                 clear;
  logic                 enable;
  logic [TIMEOUT_W-1:0] limit;
  logic                 expired;

  modport master (output clear, output enable, output limit, input expired);
  modport slave  (input clear, input enable, input limit, output expired);
endinterface

// File: rtl/test_sequencer_timer.sv
// Per-test cycle counter: cleared when a test starts, counts while waiting and
// flags expiry in the cycle where the start level reaches the limit.
module tseq_timer
  import test_seq_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input logic         clk,
  input logic         reset,
  tseq_timer_if.slave tmr
);

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W-1:0] count_d;

  // Saturates so an unlimited (limit 0) wait can never wrap back to a match.
  always_comb begin
    count_d = count_q;
    if (tmr.clear) begin
      count_d = '0;
    end else if (tmr.enable && (count_q != '1)) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The counter holds k-1 during the k-th start cycle, so limit-1 means
  // the start level has been high for exactly 'limit' cycles.
  assign tmr.expired = (tmr.limit != '0) && (count_q == (tmr.limit - TIMEOUT_W'(1)));

endmodule

// File: rtl/test_sequencer.sv
// Runs a masked set of test units one after another, with optional per-test
// timeout and abort-on-first-failure, and collects pass/fail/timeout masks.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int N_TESTS   = N_TESTS_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run,
  input  logic [N_TESTS-1:0]             enable_mask,
  input  logic [TIMEOUT_W-1:0]           timeout_limit,
  input  logic                           stop_on_fail,
  input  logic [N_TESTS-1:0]             test_done,
  input  logic [N_TESTS-1:0]             test_fail,
  output logic [N_TESTS-1:0]             test_start,
  output logic                           busy,
  output logic                           all_done,
  output logic [$clog2(N_TESTS+1)-1:0]   cur_idx,
  output logic [N_TESTS-1:0]             pass_mask,
  output logic [N_TESTS-1:0]             fail_mask,
  output logic [N_TESTS-1:0]             timeout_mask
);

  localparam int IDX_W = $clog2(N_TESTS + 1);

  test_sequencer_if #(.N_TESTS(N_TESTS))   unit_bus ();
  tseq_timer_if     #(.TIMEOUT_W(TIMEOUT_W)) tmr_bus ();

  seq_state_e            state_q, state_d;
  logic [IDX_W-1:0]      cur_idx_q, cur_idx_d;
  logic [N_TESTS-1:0]    en_q, en_d;
  logic [N_TESTS-1:0]    start_q, start_d;
  logic [N_TESTS-1:0]    pass_q, pass_d;
  logic [N_TESTS-1:0]    fail_q, fail_d;
  logic [N_TESTS-1:0]    tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0]  limit_q, limit_d;
  logic                  stop_q, stop_d;
  logic                  all_done_q, all_done_d;

  logic [N_TESTS-1:0]    sel_onehot;
  logic                  cur_en, cur_done, cur_fail;
  logic                  at_end, timed_out, leave_wait, rec_fail;

  assign unit_bus.test_done  = test_done;
  assign unit_bus.test_fail  = test_fail;
  assign unit_bus.test_start = start_q;
  assign test_start          = unit_bus.test_start;

  // Decode cur_idx once; everything indexed by the current test goes through it,
  // so cur_idx == N_TESTS naturally selects nothing.
  for (genvar gi = 0; gi < N_TESTS; gi++) begin : g_sel
    assign sel_onehot[gi] = (cur_idx_q == IDX_W'(gi));
  end

  assign cur_en     = |(en_q & sel_onehot);
  assign cur_done   = |(unit_bus.test_done & sel_onehot);
  assign cur_fail   = |(unit_bus.test_fail & sel_onehot);
  assign at_end     = (cur_idx_q == IDX_W'(N_TESTS));
  assign timed_out  = (limit_q != '0) && tmr_bus.expired;
  assign leave_wait = cur_done || timed_out;
  assign rec_fail   = cur_done ? cur_fail : timed_out;

  tseq_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tmr   (tmr_bus.slave)
  );

  assign tmr_bus.clear  = (state_q == ST_SELECT) && !at_end && cur_en;
  assign tmr_bus.enable = (state_q == ST_WAIT) && !leave_wait;
  assign tmr_bus.limit  = limit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (at_end)      state_d = ST_FINISH;
        else if (cur_en) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (leave_wait) state_d = (rec_fail && stop_q) ? ST_FINISH : ST_SELECT;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = is_busy(state_q);
    cur_idx_d  = cur_idx_q;
    en_d       = en_q;
    start_d    = start_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    tmo_d      = tmo_q;
    limit_d    = limit_q;
    stop_d     = stop_q;
    all_done_d = all_done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          cur_idx_d  = '0;
          en_d       = enable_mask;
          limit_d    = timeout_limit;
          stop_d     = stop_on_fail;
          pass_d     = '0;
          fail_d     = '0;
          tmo_d      = '0;
          all_done_d = 1'b0;
        end
      end
      ST_SELECT: begin
        if (!at_end) begin
          if (cur_en) start_d   = sel_onehot;
          else        cur_idx_d = cur_idx_q + IDX_W'(1);
        end
      end
      ST_WAIT: begin
        // A done in the expiry cycle takes precedence over the timeout.
        if (leave_wait) begin
          start_d   = '0;
          cur_idx_d = cur_idx_q + IDX_W'(1);
          if (cur_done) begin
            if (cur_fail) fail_d = fail_q | sel_onehot;
            else          pass_d = pass_q | sel_onehot;
          end else begin
            tmo_d  = tmo_q | sel_onehot;
            fail_d = fail_q | sel_onehot;
          end
        end
      end
      ST_FINISH: all_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_idx_q  <= '0;
      en_q       <= '0;
      start_q    <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      tmo_q      <= '0;
      limit_q    <= '0;
      stop_q     <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      cur_idx_q  <= cur_idx_d;
      en_q       <= en_d;
      start_q    <= start_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
      limit_q    <= limit_d;
      stop_q     <= stop_d;
      all_done_q <= all_done_d;
    end
  end

  assign all_done     = all_done_q;
  assign cur_idx      = cur_idx_q;
  assign pass_mask    = pass_q;
  assign fail_mask    = fail_q;
  assign timeout_mask = tmo_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: table of scenarios, randomized
// sequences against a per-test reference model, and reset corner cases.
module tb_test_sequencer;
  import test_seq_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [N-1:0]  enable_mask;
  logic [W-1:0]  timeout_limit;
  logic          stop_on_fail;
  logic          busy;
  logic          all_done;
  logic [IW-1:0] cur_idx;
  logic [N-1:0]  pass_mask, fail_mask, timeout_mask;

  test_sequencer_if #(.N_TESTS(N)) ubus ();

  test_sequencer #(.N_TESTS(N), .TIMEOUT_W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .enable_mask   (enable_mask),
    .timeout_limit (timeout_limit),
    .stop_on_fail  (stop_on_fail),
    .test_done     (ubus.test_done),
    .test_fail     (ubus.test_fail),
    .test_start    (ubus.test_start),
    .busy          (busy),
    .all_done      (all_done),
    .cur_idx       (cur_idx),
    .pass_mask     (pass_mask),
    .fail_mask     (fail_mask),
    .timeout_mask  (timeout_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] pm, fm, tm, st;
    logic [31:0]  dur;
    int           busy;
    int           cur;
  } res_t;

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] lim;
    logic         stop;
    logic [31:0]  lat;
    logic [N-1:0] fl;
    res_t         exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Test units: test i raises done in its lat-th start cycle (0 = never);
  // bits that are not being started carry random noise.
  logic [31:0]  cfg_lat;
  logic [N-1:0] cfg_fail;
  int           hi_cnt [N];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (ubus.test_start[i]) begin
        hi_cnt[i]++;
        ubus.test_done[i] = (cfg_lat[8*i +: 8] != 8'd0) && (hi_cnt[i] == int'(cfg_lat[8*i +: 8]));
        ubus.test_fail[i] = ubus.test_done[i] ? cfg_fail[i] : 1'($urandom_range(0, 1));
      end else begin
        hi_cnt[i] = 0;
        ubus.test_done[i] = 1'($urandom_range(0, 1));
        ubus.test_fail[i] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Observer: start run lengths, order, one-hot and busy cycle count per transaction.
  int           txn_id = 0;
  int           seen_id = 0;
  int           run_len [N];
  int           busy_cnt;
  int           last_started;
  logic [N-1:0] obs_started;
  logic [31:0]  obs_dur;
  logic         onehot_bad, idle_start_bad, order_bad;

  always @(posedge clk) begin
    #1;
    if (seen_id != txn_id) begin
      seen_id        = txn_id;
      busy_cnt       = 0;
      last_started   = -1;
      obs_started    = '0;
      obs_dur        = '0;
      onehot_bad     = 1'b0;
      idle_start_bad = 1'b0;
      order_bad      = 1'b0;
    end
    if (busy) busy_cnt++;
    if ($countones(ubus.test_start) > 1) onehot_bad = 1'b1;
    if (!busy && (ubus.test_start != '0)) idle_start_bad = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (ubus.test_start[i]) begin
        if (run_len[i] == 0) begin
          if (i <= last_started) order_bad = 1'b1;
          last_started = i;
        end
        run_len[i]++;
      end else if (run_len[i] > 0) begin
        obs_started[i]     = 1'b1;
        obs_dur[8*i +: 8]  = 8'(run_len[i]);
        run_len[i]         = 0;
      end
    end
  end

  // Reference: walk the tests in index order applying the sequencing rules.
  function automatic res_t model(input logic [N-1:0] mask, input logic [W-1:0] lim,
                                 input logic stop, input logic [31:0] lat, input logic [N-1:0] fl);
    res_t r;
    int   l;
    bit   halted;
    bit   failed;
    r.pm = '0; r.fm = '0; r.tm = '0; r.st = '0; r.dur = '0;
    r.busy = 0;
    r.cur  = N;
    halted = 0;
    for (int i = 0; i < N; i++) begin
      if (halted) break;
      r.busy++;
      if (mask[i]) begin
        l = int'(lat[8*i +: 8]);
        r.st[i] = 1'b1;
        if (l != 0 && (lim == '0 || l <= int'(lim))) begin
          r.dur[8*i +: 8] = 8'(l);
          r.busy += l;
          failed = fl[i];
          if (fl[i]) r.fm[i] = 1'b1;
          else       r.pm[i] = 1'b1;
        end else begin
          r.dur[8*i +: 8] = 8'(lim);
          r.busy += int'(lim);
          failed = 1;
          r.tm[i] = 1'b1;
          r.fm[i] = 1'b1;
        end
        if (failed && stop) begin
          halted = 1;
          r.cur  = i + 1;
        end
      end
    end
    if (!halted) r.busy++;
    return r;
  endfunction

  task automatic do_txn(input string tag, input logic [N-1:0] mask, input logic [W-1:0] lim,
                        input logic stop, input logic [31:0] lat, input logic [N-1:0] fl,
                        input res_t exp);
    @(negedge clk);
    cfg_lat       = lat;
    cfg_fail      = fl;
    enable_mask   = mask;
    timeout_limit = lim;
    stop_on_fail  = stop;
    run           = 1'b1;
    txn_id++;
    @(negedge clk);
    run = 1'b0;
    check({tag, ".accept"}, {62'd0, busy, all_done}, 64'b10);
    for (int c = 0; c < 3000; c++) begin
      if (all_done) break;
      if (busy) begin
        run           = 1'($urandom_range(0, 1));
        enable_mask   = N'($urandom);
        timeout_limit = W'($urandom);
        stop_on_fail  = 1'($urandom_range(0, 1));
      end else begin
        run = 1'b0;
      end
      @(negedge clk);
    end
    run = 1'b0;
    check({tag, ".all_done"}, 64'(all_done), 64'd1);
    check({tag, ".busy_end"}, 64'(busy), 64'd0);
    check({tag, ".pass"},     64'(pass_mask), 64'(exp.pm));
    check({tag, ".fail"},     64'(fail_mask), 64'(exp.fm));
    check({tag, ".tmo"},      64'(timeout_mask), 64'(exp.tm));
    check({tag, ".started"},  64'(obs_started), 64'(exp.st));
    check({tag, ".dur"},      64'(obs_dur), 64'(exp.dur));
    check({tag, ".busy_cyc"}, 64'(busy_cnt), 64'(exp.busy));
    check({tag, ".cur_idx"},  64'(cur_idx), 64'(exp.cur));
    check({tag, ".onehot"},   64'(onehot_bad), 64'd0);
    check({tag, ".idle_start"}, 64'(idle_start_bad), 64'd0);
    check({tag, ".order"},    64'(order_bad), 64'd0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{mask: 4'hF, lim: 16'd0, stop: 1'b0, lat: 32'h03030303, fl: 4'h0,
                exp: '{pm: 4'hF, fm: 4'h0, tm: 4'h0, st: 4'hF, dur: 32'h03030303, busy: 17, cur: 4}};
    vecs[1] = '{mask: 4'hA, lim: 16'd0, stop: 1'b0, lat: 32'h03030303, fl: 4'h0,
                exp: '{pm: 4'hA, fm: 4'h0, tm: 4'h0, st: 4'hA, dur: 32'h03000300, busy: 11, cur: 4}};
    vecs[2] = '{mask: 4'hF, lim: 16'd5, stop: 1'b0, lat: 32'h03000303, fl: 4'h0,
                exp: '{pm: 4'hB, fm: 4'h4, tm: 4'h4, st: 4'hF, dur: 32'h03050303, busy: 19, cur: 4}};
    vecs[3] = '{mask: 4'hF, lim: 16'd0, stop: 1'b1, lat: 32'h03030303, fl: 4'h2,
                exp: '{pm: 4'h1, fm: 4'h2, tm: 4'h0, st: 4'h3, dur: 32'h00000303, busy: 8, cur: 2}};
    vecs[4] = '{mask: 4'h1, lim: 16'd4, stop: 1'b0, lat: 32'h04040404, fl: 4'h0,
                exp: '{pm: 4'h1, fm: 4'h0, tm: 4'h0, st: 4'h1, dur: 32'h00000004, busy: 9, cur: 4}};
    vecs[5] = '{mask: 4'h0, lim: 16'd0, stop: 1'b0, lat: 32'h01010101, fl: 4'h0,
                exp: '{pm: 4'h0, fm: 4'h0, tm: 4'h0, st: 4'h0, dur: 32'h00000000, busy: 5, cur: 4}};
    vecs[6] = '{mask: 4'hF, lim: 16'd2, stop: 1'b1, lat: 32'h03030001, fl: 4'h0,
                exp: '{pm: 4'h1, fm: 4'h2, tm: 4'h2, st: 4'h3, dur: 32'h00000201, busy: 5, cur: 2}};
    vecs[7] = '{mask: 4'h6, lim: 16'd3, stop: 1'b0, lat: 32'h00050200, fl: 4'h4,
                exp: '{pm: 4'h2, fm: 4'h4, tm: 4'h4, st: 4'h6, dur: 32'h00030200, busy: 10, cur: 4}};

    reset = 1'b1; run = 1'b0; enable_mask = '0; timeout_limit = '0; stop_on_fail = 1'b0;
    cfg_lat = '0; cfg_fail = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {ubus.test_start, busy, all_done, 61'(cur_idx), pass_mask, fail_mask, timeout_mask}, 64'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      do_txn($sformatf("vec%0d", v), vecs[v].mask, vecs[v].lim, vecs[v].stop,
             vecs[v].lat, vecs[v].fl, vecs[v].exp);
    end

    // all_done stays high while idle until the next accepted run
    repeat (5) @(negedge clk);
    check("all_done_held", 64'(all_done), 64'd1);

    for (int t = 0; t < 25; t++) begin
      logic [N-1:0] m;
      logic [W-1:0] lm;
      logic         sp;
      logic [31:0]  lt;
      logic [N-1:0] f;
      m  = N'($urandom);
      lm = W'($urandom_range(0, 6));
      sp = 1'($urandom_range(0, 1));
      f  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        lt[8*i +: 8] = 8'($urandom_range(0, 8));
        if (lm == '0 && lt[8*i +: 8] == 8'd0) lt[8*i +: 8] = 8'($urandom_range(1, 8));
      end
      do_txn($sformatf("rnd%0d", t), m, lm, sp, lt, f, model(m, lm, sp, lt, f));
    end

    // reset wins over run in the same cycle
    @(negedge clk);
    run = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("rst_vs_run", {62'd0, busy, all_done}, 64'd0);
    run = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("rst_vs_run_idle", 64'(busy), 64'd0);

    // reset mid-WAIT on test 2, landing in the cycle where its done is high
    cfg_lat = 32'h02030202; cfg_fail = 4'h0;
    enable_mask = 4'hF; timeout_limit = '0; stop_on_fail = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (ubus.test_start[2]) break;
      @(negedge clk);
    end
    check("rst_reach_t2", 64'(ubus.test_start[2]), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_wait_start", 64'(ubus.test_start), 64'd0);
    check("rst_wait_busy", {62'd0, busy, all_done}, 64'd0);
    check("rst_wait_masks", {52'd0, pass_mask, fail_mask, timeout_mask}, 64'd0);
    check("rst_wait_cur", 64'(cur_idx), 64'd0);
    do_txn("restart", 4'hF, 16'd0, 1'b0, 32'h02020202, 4'h0,
           model(4'hF, 16'd0, 1'b0, 32'h02020202, 4'h0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
